// File: rtl/jk_exciter_if.sv
// jk_exciter_if
//   Request/response bundle between a requester and jk_exciter.
//   Parameter WIDTH : number of external JK flip-flops.
//   Signals:
//     req_valid, req_target, q_in  requester -> exciter (request and bank q)
//     req_ready                    exciter -> requester (accepting requests)
//     j, k                         exciter drive to the external JK bank
//     done, err                    one-cycle completion / mismatch pulses
//     err_mask, err_count          last per-bit mismatch, saturating error count
//   Modports: master (requester side), slave (exciter side).
interface jk_exciter_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;
  logic [7:0]       err_count;

  modport master (
    output req_valid, req_target, q_in,
    input  req_ready, j, k, done, err, err_mask, err_count
  );

  modport slave (
    input  req_valid, req_target, q_in,
    output req_ready, j, k, done, err, err_mask, err_count
  );
endinterface

// File: rtl/jk_exciter.sv
// jk_exciter
//   Drives a bank of external JK flip-flops toward a requested state, then
//   checks after SETTLE cycles that the bank really got there.
//   Parameters:
//     WIDTH  (1..16) number of flip-flops driven
//     SETTLE (1..15) check-wait cycles after the one-cycle drive
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  jk_exciter_if.slave (request handshake, bank q, j/k, status)
//   Build option:
//     JK_EXCITER_TOGGLE_EN  when defined, differing bits are driven j=k=1
//                           (toggle); otherwise explicit set/reset is used
//                           and j=k=1 is never driven.
module jk_exciter #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  jk_exciter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CHECK = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] j_nx;
  logic [WIDTH-1:0] k_nx;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] err_mask_r;
  logic [3:0]       settle_cnt;
  logic             done_r;
  logic             err_r;
  logic [7:0]       err_count_r;
  logic             accept;
  logic             last_check;

  // Handshake and end-of-check decode.
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    last_check = (state == CHECK) && (settle_cnt == LAST_CHECK);
    mismatch   = bus.q_in ^ tgt_r;
  end

  // Excitation from the q present at acceptance. The j/k flops capture this
  // at the accepting edge, so they also serve as the captured-q record: the
  // drive cannot be disturbed by later changes on req_target or q_in.
  always_comb begin
    diff = bus.q_in ^ bus.req_target;
`ifdef JK_EXCITER_TOGGLE_EN
    j_nx = diff;
    k_nx = diff;
`else
    j_nx = diff & bus.req_target;
    k_nx = diff & ~bus.req_target;
`endif
  end

  // Next-state logic; req_ready is only offered while idle.
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nx = DRIVE;
      end
      DRIVE:   state_nx = CHECK;
      CHECK:   if (last_check) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Datapath: j/k are nonzero only during the DRIVE cycle because they load
  // on acceptance and clear on every other edge. done/err are single-cycle
  // pulses raised on the final CHECK edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_r       <= '0;
      j_r         <= '0;
      k_r         <= '0;
      err_mask_r  <= '0;
      settle_cnt  <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (accept) begin
        tgt_r <= bus.req_target;
        j_r   <= j_nx;
        k_r   <= k_nx;
      end else begin
        j_r <= '0;
        k_r <= '0;
      end
      if (state == CHECK) begin
        if (last_check) begin
          settle_cnt <= '0;
          err_mask_r <= mismatch;
          done_r     <= 1'b1;
          err_r      <= |mismatch;
          if ((|mismatch) && (err_count_r != 8'hFF))
            err_count_r <= err_count_r + 8'd1;
        end else begin
          settle_cnt <= settle_cnt + 4'd1;
        end
      end
    end
  end

  // Output wiring.
  always_comb begin
    bus.j         = j_r;
    bus.k         = k_r;
    bus.done      = done_r;
    bus.err       = err_r;
    bus.err_mask  = err_mask_r;
    bus.err_count = err_count_r;
  end

endmodule

// File: doc/jk_exciter.md
JK_EXCITER -- requirements
Module: jk_exciter

Interface
REQ-001 Parameter WIDTH, default 4: number of external JK flip-flops driven, legal 1..16.
REQ-002 Parameter SETTLE, default 1: check-wait cycles after the drive cycle, legal 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-low.
REQ-005 req_valid  input  1  request carries a new target state.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_target  input  WIDTH  desired next state of the flip-flop bank.
REQ-008 q_in  input  WIDTH  present q of the external flip-flop bank.
REQ-009 j  output  WIDTH  registered J drive, one bit per flip-flop.
REQ-010 k  output  WIDTH  registered K drive, one bit per flip-flop.
REQ-011 done  output  1  one-cycle pulse, request completed.
REQ-012 err  output  1  one-cycle pulse coincident with done when the checked q_in differed from the target.
REQ-013 err_mask  output  WIDTH  per-bit mismatch of the last check, held until the next check.
REQ-014 err_count  output  8  saturating count of checks with err.

Function
REQ-015 FSM states IDLE, DRIVE, CHECK; req_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1; req_target and q_in are captured into tgt_r and qs_r at that edge; IDLE->DRIVE.
REQ-017 DRIVE lasts exactly one cycle; j/k SHALL hold the excitation per bit: qs=tgt -> j=0,k=0; qs=0,tgt=1 -> j=1,k=0; qs=1,tgt=0 -> j=0,k=1.
REQ-018 DRIVE->CHECK unconditionally; j=k=0 in every cycle outside DRIVE.
REQ-019 CHECK lasts SETTLE cycles, counted by an internal counter; on the final CHECK edge, err_mask <= q_in XOR tgt_r and the FSM returns to IDLE.
REQ-020 done SHALL be 1 for exactly the single cycle following the final CHECK edge; err SHALL be 1 in that same cycle iff err_mask is nonzero.
REQ-021 Latency: acceptance at edge E0 -> done high in the cycle after edge E(1+SETTLE); SETTLE=1 gives done in the cycle after E2.
REQ-022 A new request SHALL be accepted in the same cycle done is high (back-to-back, throughput one request per 2+SETTLE cycles).
REQ-023 err_count increments by 1 per err pulse, saturating at 255, never wrapping.
REQ-024 req_valid asserted outside IDLE is ignored; req_target/q_in changes after capture do not affect j/k.

Reset
REQ-025 rst=0 SHALL immediately force FSM to IDLE, j=0, k=0, done=0, err=0, err_mask=0, err_count=0, settle counter=0, regardless of clock.
REQ-026 Reset asserted during DRIVE or CHECK abandons the request with no done/err pulse; req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro JK_EXCITER_TOGGLE_EN: when defined, any bit with qs!=tgt SHALL be driven j=1,k=1 (toggle) in DRIVE; matching bits stay j=0,k=0.
REQ-028 Without JK_EXCITER_TOGGLE_EN, the explicit set/reset encoding of REQ-017 applies; j=k=1 SHALL never be driven.

Verification
REQ-029 Bench models a 4-bit JK bank on clk with async active-low rst; WIDTH=4, SETTLE=1 unless stated.
REQ-030 q=0000, target 1010 -> DRIVE j=1010,k=0000; done high after E2, err=0, err_mask=0000.
REQ-031 q=1111, target 0110 -> DRIVE j=0000,k=1001 (toggle build: j=k=1001); done, err=0.
REQ-032 Bank model with bit0 stuck at 0, target 0001 -> err=1 with done, err_mask=0001, err_count=1; 256 such requests -> err_count=255.
REQ-033 Two requests back-to-back (req_valid held high) -> done pulses every 3 cycles, second accepted in first done cycle.
REQ-034 rst pulled low mid-CHECK with SETTLE=4 -> j=k=0 immediately, no done, err_count=0, req_ready=1 after release.
